// File: rtl/outport_vc_arbiter_if.sv
// Handshake bundle between an output port's VC allocator and its inports.
// Parameters must match the outport_vc_arbiter instance they connect to.
interface outport_vc_arbiter_if #(
    parameter int no_inport = 3,
    parameter int floorplusone_log2_no_inport = 2,
    parameter int no_vc = 2,
    parameter int floorplusone_log2_no_vc = 2
);
    logic [no_inport-1:0] req_vec;
    logic [no_inport*no_vc-1:0] allow_vcs_vec;
    logic [no_inport-1:0] release_vec;
    logic flit_sent;
    logic [floorplusone_log2_no_vc-1:0] sent_vc_no;
    logic credit_ret;
    logic [floorplusone_log2_no_vc-1:0] credit_vc_no;
    logic [no_inport-1:0] grant_vec;
    logic [floorplusone_log2_no_vc-1:0] grant_vc_no;
    logic [no_inport*floorplusone_log2_no_vc-1:0] owned_vc_no_vec;
    logic [no_vc-1:0] credit_ok_vec;
    logic err;
    logic busy;

    modport master (
        output req_vec, allow_vcs_vec, release_vec,
        output flit_sent, sent_vc_no,
        output credit_ret, credit_vc_no,
        input grant_vec, grant_vc_no, owned_vc_no_vec,
        input credit_ok_vec, err, busy
    );

    modport slave (
        input req_vec, allow_vcs_vec, release_vec,
        input flit_sent, sent_vc_no,
        input credit_ret, credit_vc_no,
        output grant_vec, grant_vc_no, owned_vc_no_vec,
        output credit_ok_vec, err, busy
    );
endinterface

// File: rtl/outport_vc_arbiter_rr.sv
// Round-robin search: first set request at or above ptr, wrapping.
// Expects ptr < n.
module rr_arbiter #(
    parameter int n = 3,
    parameter int pw = 2
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] ptr,
    output logic [n-1:0]  gnt,
    output logic          valid
);
    always_comb begin
        gnt = '0;
        valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < n; i++) begin
                if (!valid && req[i] &&
                    i == (int'(ptr) + k) % n) begin
                    gnt[i] = 1'b1;
                    valid = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/outport_vc_arbiter.sv
// Output-port VC allocator: per-VC ownership and downstream credits,
// one round-robin grant per cycle to an inport needing a VC.
module outport_vc_arbiter #(
    parameter int no_inport = 3,
    parameter int floorplusone_log2_no_inport = 2,
    parameter int no_vc = 2,
    parameter int floorplusone_log2_no_vc = 2,
    parameter int buf_size = 2,
    parameter int floorplusone_log2_buf_size = 2
) (
    input logic clk,
    input logic reset,
    outport_vc_arbiter_if.slave bus
);
    localparam int IW = floorplusone_log2_no_inport;
    localparam int VW = floorplusone_log2_no_vc;
    localparam int CW = floorplusone_log2_buf_size;

    logic [no_vc-1:0] owner_valid;
    logic [IW-1:0] owner_idx [no_vc];
    logic [CW-1:0] credit [no_vc];
    logic [CW-1:0] credit_nxt [no_vc];
    logic [IW-1:0] rr_ptr;
    logic [no_inport-1:0] grant_q;
    logic [VW-1:0] grant_vc_q;
    logic err_q;

    logic [no_inport-1:0] owns, elig, win_oh;
    logic [no_vc-1:0] free_vc, rel_vc, bad, win_allow;
    logic [no_inport*VW-1:0] owned_vc;
    logic [IW-1:0] win_idx;
    logic [VW-1:0] win_vc;
    logic win_valid, vc_found;

    always_comb begin
        owns = '0;
        owned_vc = '0;
        rel_vc = '0;
        free_vc = '0;
        elig = '0;
        for (int v = 0; v < no_vc; v++) begin
            for (int i = 0; i < no_inport; i++) begin
                if (owner_valid[v] && owner_idx[v] == IW'(i)) begin
                    owns[i] = 1'b1;
                    owned_vc[i*VW +: VW] = VW'(v);
                    rel_vc[v] = bus.release_vec[i];
                end
            end
            free_vc[v] = !owner_valid[v] && credit[v] != '0;
        end
        for (int i = 0; i < no_inport; i++) begin
            elig[i] = bus.req_vec[i] && !owns[i] &&
                |(bus.allow_vcs_vec[i*no_vc +: no_vc] & free_vc);
        end
    end

    rr_arbiter #(
        .n(no_inport),
        .pw(IW)
    ) u_rr (
        .req(elig),
        .ptr(rr_ptr),
        .gnt(win_oh),
        .valid(win_valid)
    );

    always_comb begin
        win_idx = '0;
        win_allow = '0;
        win_vc = '0;
        vc_found = 1'b0;
        for (int i = 0; i < no_inport; i++) begin
            if (win_oh[i]) begin
                win_idx = IW'(i);
                win_allow = bus.allow_vcs_vec[i*no_vc +: no_vc];
            end
        end
        for (int v = 0; v < no_vc; v++) begin
            if (!vc_found && win_allow[v] && free_vc[v]) begin
                win_vc = VW'(v);
                vc_found = 1'b1;
            end
        end
    end

    // Simultaneous send and return on one VC cancel out.
    always_comb begin
        bad = '0;
        for (int v = 0; v < no_vc; v++) begin
            credit_nxt[v] = credit[v];
            if (bus.flit_sent && bus.sent_vc_no == VW'(v) &&
                !(bus.credit_ret && bus.credit_vc_no == VW'(v))) begin
                if (credit[v] == '0) bad[v] = 1'b1;
                else credit_nxt[v] = credit[v] - 1'b1;
            end
            if (bus.credit_ret && bus.credit_vc_no == VW'(v) &&
                !(bus.flit_sent && bus.sent_vc_no == VW'(v))) begin
                if (credit[v] == CW'(buf_size)) bad[v] = 1'b1;
                else credit_nxt[v] = credit[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_valid <= '0;
            for (int v = 0; v < no_vc; v++) begin
                owner_idx[v] <= '0;
                credit[v] <= CW'(buf_size);
            end
            rr_ptr <= '0;
            grant_q <= '0;
            grant_vc_q <= '0;
            err_q <= 1'b0;
        end else begin
            grant_q <= win_valid ? win_oh : '0;
            grant_vc_q <= win_valid ? win_vc : '0;
            err_q <= |bad;
            if (win_valid)
                rr_ptr <= (win_idx == IW'(no_inport - 1)) ?
                          '0 : win_idx + 1'b1;
            for (int v = 0; v < no_vc; v++) begin
                credit[v] <= credit_nxt[v];
                if (rel_vc[v]) owner_valid[v] <= 1'b0;
                if (win_valid && win_vc == VW'(v)) begin
                    owner_valid[v] <= 1'b1;
                    owner_idx[v] <= win_idx;
                end
            end
        end
    end

    always_comb begin
        bus.credit_ok_vec = '0;
        for (int v = 0; v < no_vc; v++)
            bus.credit_ok_vec[v] = credit[v] != '0;
    end

    assign bus.grant_vec = grant_q;
    assign bus.grant_vc_no = grant_vc_q;
    assign bus.owned_vc_no_vec = owned_vc;
    assign bus.err = err_q;
    assign bus.busy = |owner_valid;
endmodule
